inst_fetch: RTL and testbench

Fetch stage sitting directly upstream of `InstMemory`. It owns the program counter, drives the word address into the instruction memory, and captures the returned words into a 2-entry output buffer. Decode pulls those words through a valid/ready handshake. It supports back-pressure from decode and single-cycle PC redirects for branches and jumps. Throughput is one instruction per cycle while decode is ready.

---
 rtl/inst_fetch.sv | 89 ++++++++
 tb/tb_inst_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses InstMemory (1-cycle read) and buffers returned words in a 2-entry FIFO.
// Latency 2 edges from reset release or redirect to valid output; decode back-pressure stops issue once in-flight + buffered reaches 2.
module inst_fetch #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_q;
    logic              r_issue_q;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_data [2];
    logic [ADDR_W-1:0] r_epc  [2];

    logic       w_pop;
    logic       w_push;
    logic       w_issue;
    logic [2:0] w_occ;
    logic [1:0] w_cnt_post;
    logic       w_slot;

    assign inst_valid = (r_count != 2'd0);
    assign inst_data  = r_data[0];
    assign inst_pc    = r_epc[0];
    assign mem_addr   = redirect_valid ? redirect_addr : r_pc;

    assign w_pop      = inst_valid & inst_ready;
    assign w_push     = r_issue_q & ~redirect_valid;
    // Occupancy counts the read in flight, so the FIFO can never be overrun.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_issue_q} - {2'b00, w_pop};
    assign w_issue    = (w_occ < 3'd2);
    assign w_cnt_post = r_count - {1'b0, w_pop};
    assign w_slot     = w_cnt_post[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pc_q    <= '0;
            r_issue_q <= 1'b0;
            r_count   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_epc[i]  <= '0;
            end
        end else if (redirect_valid) begin
            r_pc      <= redirect_addr + PC_INC;
            r_pc_q    <= redirect_addr;
            r_issue_q <= 1'b1;
            r_count   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_epc[i]  <= '0;
            end
        end else begin
            // Head-at-slot-0 shift FIFO; the push write after the shift takes precedence.
            if (w_pop) begin
                r_data[0] <= r_data[1];
                r_epc[0]  <= r_epc[1];
            end
            if (w_push) begin
                r_data[w_slot] <= mem_data;
                r_epc[w_slot]  <= r_pc_q;
            end
            r_count <= w_cnt_post + {1'b0, w_push};
            if (w_issue) begin
                r_pc      <= r_pc + PC_INC;
                r_pc_q    <= r_pc;
                r_issue_q <= 1'b1;
            end else begin
                r_issue_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a 1-cycle-latency memory model; word k holds {16'hBEEF, k}.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  mem_addr;
    logic [63:0] mem_data;
    logic        redirect_valid;
    logic [5:0]  redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_data;
    logic [5:0]  inst_pc;

    int n_chk  = 0;
    int n_pass = 0;

    inst_fetch #(.ADDR_W(6), .DATA_W(64), .RESET_PC(6'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [5:0] a);
        return {16'hBEEF, 40'h0, 2'b00, a};
    endfunction

    always @(posedge clk) mem_data <= mem_word(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input string tag, input logic [5:0] k);
        chk({tag, "_valid"}, {63'd0, inst_valid}, 64'd1);
        chk({tag, "_pc"},    {58'd0, inst_pc},    {58'd0, k});
        chk({tag, "_data"},  inst_data,           mem_word(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        inst_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    {63'd0, inst_valid}, 64'd0);
        chk("rst_data",     inst_data,           64'd0);
        chk("rst_pc",       {58'd0, inst_pc},    64'd0);
        chk("rst_mem_addr", {58'd0, mem_addr},   64'd0);
        chk("rst_count",    {62'd0, dut.r_count}, 64'd0);
        rst = 1'b0;

        // Sequential stream: valid appears after the second edge.
        cyc();
        chk("e1_valid",    {63'd0, inst_valid}, 64'd0);
        chk("e1_mem_addr", {58'd0, mem_addr},   64'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_inst("seq", 6'(k));
        end

        // Back-pressure while pc 3 is at the head.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_inst("stall", 6'd3);
            chk("stall_mem_addr", {58'd0, mem_addr}, 64'd5);
        end
        chk("stall_count", {62'd0, dut.r_count}, 64'd2);
        inst_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            cyc();
            expect_inst("release", 6'(k));
        end

        // Redirect to 20 while pc 7 is shown.
        redirect_valid = 1'b1;
        redirect_addr  = 6'd20;
        #1;
        chk("redir_mem_addr", {58'd0, mem_addr}, 64'd20);
        cyc();
        redirect_valid = 1'b0;
        chk("redir_bubble", {63'd0, inst_valid}, 64'd0);
        for (int k = 20; k < 24; k++) begin
            cyc();
            expect_inst("redir", 6'(k));
        end

        // Wrap-around past 63.
        redirect_valid = 1'b1;
        redirect_addr  = 6'd62;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_bubble", {63'd0, inst_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_inst("wrap", 6'(62 + k));
        end

        // Redirect out of a full stall.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_inst("full_hold", 6'd1);
        end
        chk("full_count", {62'd0, dut.r_count}, 64'd2);
        redirect_valid = 1'b1;
        redirect_addr  = 6'd10;
        inst_ready     = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        chk("flush_valid", {63'd0, inst_valid},   64'd0);
        chk("flush_count", {62'd0, dut.r_count},  64'd0);
        for (int k = 10; k < 13; k++) begin
            cyc();
            expect_inst("full_redir", 6'(k));
        end

        // Asynchronous reset mid-cycle with pc 12 shown.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    {63'd0, inst_valid}, 64'd0);
        chk("arst_mem_addr", {58'd0, mem_addr},   64'd0);
        chk("arst_pc",       {58'd0, inst_pc},    64'd0);
        chk("arst_data",     inst_data,           64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        chk("restart_e1_valid", {63'd0, inst_valid}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_inst("restart", 6'(k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
